// File: rtl/osnt_output_demux.sv
// osnt_output_demux
// Routes each whole packet of a single 64-bit AXI4-Stream to any subset of four
// MAC output streams. The routing comes from the first word's tuser byte
// [31:24]: only the even (MAC) bits 24/26/28/30 count, and the odd (DMA) bits
// are ignored. A packet with no MAC destination is dropped. Every output has a
// single registered stage. Multicast words are accepted only when all selected
// stages are free, so the copies stay word-aligned.
// Optional feature macro: OSNT_OUTPUT_DEMUX_DROP_COUNT_EN adds pkt_drop_count.
module osnt_output_demux #(
  parameter int C_M_AXIS_DATA_WIDTH  = 64,
  parameter int C_S_AXIS_DATA_WIDTH  = 64,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
  input  logic                                 axi_aclk,
  input  logic                                 axi_reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
  input  logic [(C_S_AXIS_DATA_WIDTH/8)-1:0]   s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
  input  logic                                 s_axis_tvalid,
  input  logic                                 s_axis_tlast,
  output logic                                 s_axis_tready,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_tdata_0,
  output logic [(C_M_AXIS_DATA_WIDTH/8)-1:0]   m_axis_tstrb_0,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser_0,
  output logic                                 m_axis_tvalid_0,
  output logic                                 m_axis_tlast_0,
  input  logic                                 m_axis_tready_0,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_tdata_1,
  output logic [(C_M_AXIS_DATA_WIDTH/8)-1:0]   m_axis_tstrb_1,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser_1,
  output logic                                 m_axis_tvalid_1,
  output logic                                 m_axis_tlast_1,
  input  logic                                 m_axis_tready_1,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_tdata_2,
  output logic [(C_M_AXIS_DATA_WIDTH/8)-1:0]   m_axis_tstrb_2,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser_2,
  output logic                                 m_axis_tvalid_2,
  output logic                                 m_axis_tlast_2,
  input  logic                                 m_axis_tready_2,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_tdata_3,
  output logic [(C_M_AXIS_DATA_WIDTH/8)-1:0]   m_axis_tstrb_3,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser_3,
  output logic                                 m_axis_tvalid_3,
  output logic                                 m_axis_tlast_3,
  input  logic                                 m_axis_tready_3
`ifdef OSNT_OUTPUT_DEMUX_DROP_COUNT_EN
  ,
  output logic [31:0]                          pkt_drop_count
`endif
);

  localparam int STRB_W = C_M_AXIS_DATA_WIDTH / 8;

  localparam logic [1:0] ST_SOP  = 2'd0;
  localparam logic [1:0] ST_FWD  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [1:0] state_r;
  logic [1:0] state_nxt_s;
  logic [3:0] dst_s;
  logic [3:0] dst_q_r;
  logic [3:0] sel_s;
  logic [3:0] free_s;
  logic [3:0] load_s;
  logic [3:0] m_tready_s;
  logic       s_tready_s;
  logic       accept_s;

  logic [3:0]                      tvalid_r;
  logic [3:0]                      tlast_r;
  logic [C_M_AXIS_DATA_WIDTH-1:0]  tdata_r [4];
  logic [STRB_W-1:0]               tstrb_r [4];
  logic [C_M_AXIS_TUSER_WIDTH-1:0] tuser_r [4];

  assign dst_s      = {s_axis_tuser[30], s_axis_tuser[28], s_axis_tuser[26], s_axis_tuser[24]};
  assign m_tready_s = {m_axis_tready_3, m_axis_tready_2, m_axis_tready_1, m_axis_tready_0};
  // A stage can take a new word if it is empty or being drained this cycle.
  assign free_s     = ~tvalid_r | m_tready_s;
  assign accept_s   = s_axis_tvalid & s_tready_s;
  assign load_s     = sel_s & {4{accept_s}};
  assign s_axis_tready = s_tready_s;

  // Route selection and input ready: all selected stages must be free together.
  always_comb begin
    sel_s      = 4'd0;
    s_tready_s = 1'b0;
    case (state_r)
      ST_SOP: begin
        sel_s      = dst_s;
        s_tready_s = s_axis_tvalid & ((dst_s & ~free_s) == 4'd0);
      end
      ST_FWD: begin
        sel_s      = dst_q_r;
        s_tready_s = ((dst_q_r & ~free_s) == 4'd0);
      end
      ST_DROP: begin
        sel_s      = 4'd0;
        s_tready_s = 1'b1;
      end
      default: begin
        sel_s      = 4'd0;
        s_tready_s = 1'b0;
      end
    endcase
  end

  // Packet framing: decide where the next accepted word belongs.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_SOP: begin
        if (accept_s && !s_axis_tlast) begin
          state_nxt_s = (dst_s != 4'd0) ? ST_FWD : ST_DROP;
        end else begin
          state_nxt_s = ST_SOP;
        end
      end
      ST_FWD, ST_DROP: begin
        if (accept_s && s_axis_tlast) begin
          state_nxt_s = ST_SOP;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: state_nxt_s = ST_SOP;
    endcase
  end

  // FSM state and the destination mask held for the packet body.
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      state_r <= ST_SOP;
      dst_q_r <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ST_SOP && accept_s && dst_s != 4'd0) begin
        dst_q_r <= dst_s;
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_out
    // Output stage: load on a routed accept, retire when downstream takes it.
    always_ff @(posedge axi_aclk or posedge axi_reset) begin
      if (axi_reset) begin
        tvalid_r[g] <= 1'b0;
        tlast_r[g]  <= 1'b0;
        tdata_r[g]  <= '0;
        tstrb_r[g]  <= '0;
        tuser_r[g]  <= '0;
      end else if (load_s[g]) begin
        tvalid_r[g] <= 1'b1;
        tlast_r[g]  <= s_axis_tlast;
        tdata_r[g]  <= s_axis_tdata;
        tstrb_r[g]  <= s_axis_tstrb;
        tuser_r[g]  <= s_axis_tuser;
      end else if (m_tready_s[g]) begin
        tvalid_r[g] <= 1'b0;
      end
    end
  end

  assign m_axis_tvalid_0 = tvalid_r[0];
  assign m_axis_tlast_0  = tlast_r[0];
  assign m_axis_tdata_0  = tdata_r[0];
  assign m_axis_tstrb_0  = tstrb_r[0];
  assign m_axis_tuser_0  = tuser_r[0];
  assign m_axis_tvalid_1 = tvalid_r[1];
  assign m_axis_tlast_1  = tlast_r[1];
  assign m_axis_tdata_1  = tdata_r[1];
  assign m_axis_tstrb_1  = tstrb_r[1];
  assign m_axis_tuser_1  = tuser_r[1];
  assign m_axis_tvalid_2 = tvalid_r[2];
  assign m_axis_tlast_2  = tlast_r[2];
  assign m_axis_tdata_2  = tdata_r[2];
  assign m_axis_tstrb_2  = tstrb_r[2];
  assign m_axis_tuser_2  = tuser_r[2];
  assign m_axis_tvalid_3 = tvalid_r[3];
  assign m_axis_tlast_3  = tlast_r[3];
  assign m_axis_tdata_3  = tdata_r[3];
  assign m_axis_tstrb_3  = tstrb_r[3];
  assign m_axis_tuser_3  = tuser_r[3];

`ifdef OSNT_OUTPUT_DEMUX_DROP_COUNT_EN
  logic [31:0] drop_cnt_r;

  // Count packets whose first word carries no MAC destination; wraps naturally.
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      drop_cnt_r <= 32'd0;
    end else if (state_r == ST_SOP && accept_s && dst_s == 4'd0) begin
      drop_cnt_r <= drop_cnt_r + 32'd1;
    end
  end

  assign pkt_drop_count = drop_cnt_r;
`endif

endmodule
